// File: rtl/audio_pkg.sv
// Shared audio types for the DAC output path: default sample width,
// serializer state encoding and the signed sample type used upstream.
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic [2:0] {
    S_LOAD,
    S_DELAY,
    S_LEFT,
    S_RIGHT,
    S_TAIL,
    S_PAD
  } dac_ser_state_t;

  typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;

endpackage : audio_pkg

// File: rtl/dac_frame_serializer.sv
// Serial output stage for the WM8731 DAC. Every LR frame (the frame clock
// doubles as the reset) it captures one stereo pair and shifts it out
// MSB-first, left then right, then idles with the line silent until the next
// frame restarts it. It pulses sample_req once per completed frame so the
// upstream fetch can prepare the next pair.
module dac_frame_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUDIO_DATA_W,
  parameter int MSB_DELAY = 1,
  parameter int PAD_BITS  = 0
) (
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  input  logic              mute,
  output logic              AUD_DACDAT,
  output logic              sample_req,
  output logic              underrun,
  output logic              lr_phase,
  output logic              frame_done
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_MAX = (MSB_DELAY > PAD_BITS) ? MSB_DELAY : PAD_BITS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((MSB_DELAY > 0) ? MSB_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'((PAD_BITS > 0) ? PAD_BITS - 1 : 0);

  localparam dac_ser_state_t AFTER_LOAD  = (MSB_DELAY > 0) ? S_DELAY : S_LEFT;
  localparam dac_ser_state_t AFTER_RIGHT = (PAD_BITS > 0) ? S_TAIL : S_PAD;

  dac_ser_state_t     state;
  dac_ser_state_t     state_d;
  logic [FRAME_W-1:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  // The delay and tail phases never overlap, so one counter serves both.
  logic [CNT_W-1:0]   dly_cnt;
  logic               last_bit;
  logic               shifting;

  // Next-state decode and per-cycle qualifiers.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state;
    last_bit = (bit_cnt == LAST_BIT);
    shifting = (state == S_LEFT) || (state == S_RIGHT);
    case (state)
      S_LOAD:  state_d = AFTER_LOAD;
      S_DELAY: if (dly_cnt == DLY_LAST) state_d = S_LEFT;
      S_LEFT:  if (last_bit) state_d = S_RIGHT;
      S_RIGHT: if (last_bit) state_d = AFTER_RIGHT;
      S_TAIL:  if (dly_cnt == PAD_LAST) state_d = S_PAD;
      S_PAD:   state_d = S_PAD;
      default: state_d = S_PAD;
    endcase
  end

  // State register; the frame clock restarts the block at LOAD.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) state <= S_LOAD;
    else             state <= state_d;
  end

  // Datapath: capture the pair at LOAD, shift during LEFT/RIGHT, count delay/tail cycles.
  // NOTE: the shift register is a plain flop array, not a RAM, so it can take the async clear.
  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      shreg   <= '0;
      bit_cnt <= '0;
      dly_cnt <= '0;
    end else begin
      if (state == S_LOAD) begin
        shreg <= (sample_valid && !mute) ? {sample_l, sample_r} : '0;
      end else if (shifting) begin
        shreg <= shreg << 1;
      end

      if (shifting) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end

      if ((state == S_DELAY) || (state == S_TAIL)) begin
        dly_cnt <= (state_d != state) ? '0 : dly_cnt + 1'b1;
      end else begin
        dly_cnt <= '0;
      end
    end
  end

  // Registered outputs, aligned with the bit currently on the serial line.
  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      AUD_DACDAT <= 1'b0;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
      lr_phase   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      AUD_DACDAT <= shifting ? shreg[FRAME_W-1] : 1'b0;
      // The pulse coincides with the last right-channel bit leaving the shifter.
      sample_req <= (state == S_RIGHT) && last_bit;
      frame_done <= (state == S_PAD);
      if (state == S_LOAD)  underrun <= !sample_valid;
      // Once right bits start, the phase stays high through tail and pad.
      if (state == S_RIGHT) lr_phase <= 1'b1;
    end
  end

endmodule : dac_frame_serializer

// File: tb/tb_dac_frame_serializer.sv
// Directed bench for dac_frame_serializer. Three instances share the inputs:
// I2S timing (delay 1), left-justified timing (delay 0), and a variant with a
// 2-cycle delay and 3 tail bits. Expected per-cycle outputs come from a small
// timing model written from the frame description.
module tb_dac_frame_serializer;
  import audio_pkg::*;

  logic          AUD_BCLK = 1'b0;
  logic          lrck     = 1'b1;
  audio_sample_t sl       = '0;
  audio_sample_t sr       = '0;
  logic          valid    = 1'b0;
  logic          mute     = 1'b0;

  logic dat0, req0, ur0, ph0, done0;
  logic dat1, req1, ur1, ph1, done1;
  logic dat2, req2, ur2, ph2, done2;
  logic [2:0] dat_v, req_v, ur_v, ph_v, done_v;

  assign dat_v  = {dat2, dat1, dat0};
  assign req_v  = {req2, req1, req0};
  assign ur_v   = {ur2, ur1, ur0};
  assign ph_v   = {ph2, ph1, ph0};
  assign done_v = {done2, done1, done0};

  dac_frame_serializer #(.DATA_W(16), .MSB_DELAY(1), .PAD_BITS(0)) dut_i2s (
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(lrck), .sample_l(sl), .sample_r(sr),
    .sample_valid(valid), .mute(mute), .AUD_DACDAT(dat0), .sample_req(req0),
    .underrun(ur0), .lr_phase(ph0), .frame_done(done0));

  dac_frame_serializer #(.DATA_W(16), .MSB_DELAY(0), .PAD_BITS(0)) dut_lj (
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(lrck), .sample_l(sl), .sample_r(sr),
    .sample_valid(valid), .mute(mute), .AUD_DACDAT(dat1), .sample_req(req1),
    .underrun(ur1), .lr_phase(ph1), .frame_done(done1));

  dac_frame_serializer #(.DATA_W(16), .MSB_DELAY(2), .PAD_BITS(3)) dut_pad (
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(lrck), .sample_l(sl), .sample_r(sr),
    .sample_valid(valid), .mute(mute), .AUD_DACDAT(dat2), .sample_req(req2),
    .underrun(ur2), .lr_phase(ph2), .frame_done(done2));

  always #5 AUD_BCLK = ~AUD_BCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt [3];

  // Per-instance timing parameters used by the model.
  function automatic int dly_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  function automatic int pad_of(int i);
    return (i == 2) ? 3 : 0;
  endfunction

  // Bit n (1..32) of the frame is on the line after rise k = 1 + delay + n.
  function automatic logic exp_dat(int d, logic [31:0] word, int k);
    int n;
    n = k - 1 - d;
    if (n >= 1 && n <= 32) return word[32-n];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of every instance at cycle k after deassert (k=0: in reset).
  task automatic check_all(input string tn, input int k, input logic [31:0] word, input logic v);
    for (int i = 0; i < 3; i++) begin
      int d, p;
      d = dly_of(i);
      p = pad_of(i);
      check($sformatf("%s dut%0d k=%0d dat", tn, i, k), 32'(dat_v[i]),
            32'((k >= 1) ? exp_dat(d, word, k) : 1'b0));
      check($sformatf("%s dut%0d k=%0d req", tn, i, k), 32'(req_v[i]), 32'(k == 33 + d));
      check($sformatf("%s dut%0d k=%0d underrun", tn, i, k), 32'(ur_v[i]), 32'((k >= 1) && !v));
      check($sformatf("%s dut%0d k=%0d lr_phase", tn, i, k), 32'(ph_v[i]), 32'(k >= 18 + d));
      check($sformatf("%s dut%0d k=%0d frame_done", tn, i, k), 32'(done_v[i]), 32'(k >= 34 + d + p));
      if (req_v[i] === 1'b1) req_cnt[i]++;
    end
  endtask

  // Hold the frame clock high for a few BCLKs, load inputs, release it and
  // check ncyc cycles. Inputs are scrambled after LOAD to prove they are ignored.
  task automatic run_frame(input string tn, input logic [15:0] l, input logic [15:0] r,
                           input logic v, input logic m, input int ncyc);
    logic [31:0] word;
    word = (v && !m) ? {l, r} : 32'h0;
    @(negedge AUD_BCLK);
    lrck = 1'b1;
    repeat (3) begin
      @(negedge AUD_BCLK);
      check_all({tn, " rst"}, 0, word, v);
    end
    sl    = l;
    sr    = r;
    valid = v;
    mute  = m;
    for (int i = 0; i < 3; i++) req_cnt[i] = 0;
    lrck = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge AUD_BCLK);
      check_all(tn, k, word, v);
      if (k == 1) begin
        sl    = ~l;
        sr    = ~r;
        valid = ~v;
        mute  = ~m;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s dut%0d req_count", tn, i), 32'(req_cnt[i]),
            (ncyc >= 33 + dly_of(i)) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // 1: normal I2S frame
    run_frame("t1_basic", 16'hA5C3, 16'h0F01, 1'b1, 1'b0, 40);
    // 2: underrun, no valid pair at LOAD
    run_frame("t2_underrun", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40);
    // 3: mute forces a zero frame but the pair is still consumed
    run_frame("t3_mute", 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 40);
    // 4: frame clock returns after 10 data bits on the I2S instance
    run_frame("t4_short", 16'hA5C3, 16'h0F01, 1'b1, 1'b0, 12);
    check("t4 dat_before_abort", 32'(dat0), 32'd1);
    #1 lrck = 1'b1;
    #1;
    check("t4 async_dat0", 32'(dat0), 32'd0);
    check("t4 async_dat2", 32'(dat2), 32'd0);
    check("t4 async_req", 32'(req_v), 32'd0);
    check("t4 async_phase", 32'(ph_v), 32'd0);
    // next frame after the abort must be clean
    run_frame("t4_next", 16'h1234, 16'hFEDC, 1'b1, 1'b0, 40);
    // 5: long frame, pad holds indefinitely
    run_frame("t5_long", 16'h8001, 16'h4002, 1'b1, 1'b0, 100);
    // 6: single MSB set; left-justified instance shows it on rise 2
    run_frame("t6_msb", 16'h8000, 16'h0000, 1'b1, 1'b0, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dac_frame_serializer
